// File: rtl/mil_manchester_transmitter.sv
// mil_manchester_transmitter
//   Last stage of the SPI-to-MIL path. Takes 16-bit words from the
//   service-protocol encoder through a one-word holding register and sends
//   each one as a MIL-STD-1553 Manchester-II frame: a 3-bit sync
//   (command/status or data), 16 data bits MSB first, and an odd parity bit.
//   That is 40 half-bits of CLK_PER_HALFBIT cycles each. Words that are
//   already waiting leave back to back with no idle time. After the last
//   word of a burst the line is held idle for GAP_HALFBITS half-bits.
//
// Optional feature: define MIL_TX_PARITY_INJECT_EN to add the parity_inject
//   input. A word captured with parity_inject=1 is sent with inverted parity.
//
// Ports
//   clk, rst        system clock; synchronous active-low reset
//   in_data/in_type word and sync type (1 = command/status, 0 = data)
//   in_request      encoder has a word pending
//   parity_inject   (optional) corrupt the parity of this word
//   in_done         1-cycle pulse: word captured into the holding register
//   line_p/line_n   differential line phases, both 0 while inhibited
//   tx_enable       transceiver drive enable
//   tx_busy         word held, frame in flight, or gap still running
module mil_manchester_transmitter #(
    parameter int CLK_PER_HALFBIT = 25,
    parameter int GAP_HALFBITS    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_type,
    input  logic        in_request,
`ifdef MIL_TX_PARITY_INJECT_EN
    input  logic        parity_inject,
`endif
    output logic        in_done,
    output logic        line_p,
    output logic        line_n,
    output logic        tx_enable,
    output logic        tx_busy
);

    localparam int FRAME_HB = 40;
    localparam int CW       = (CLK_PER_HALFBIT > 1) ? $clog2(CLK_PER_HALFBIT) : 1;
    localparam int IDX_MAX  = (GAP_HALFBITS > FRAME_HB) ? GAP_HALFBITS : FRAME_HB;
    localparam int IW       = $clog2(IDX_MAX);

    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_PER_HALFBIT - 1);
    localparam logic [IW-1:0] FRAME_LAST = IW'(FRAME_HB - 1);
    localparam logic [IW-1:0] GAP_LAST   = IW'(GAP_HALFBITS - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;     // cycle within the current half-bit
    logic [IW-1:0] idx_q, idx_d;     // half-bit index within frame or gap
    logic [39:0]   frame_q, frame_d; // half-bit levels, MSB goes out first
    logic          hold_full_q, hold_full_d;
    logic [15:0]   hold_data_q, hold_data_d;
    logic          hold_type_q, hold_type_d;
    logic          hold_inj_q;
    logic          in_done_q, in_done_d;
    logic          line_p_q, line_p_d;
    logic          line_n_q, line_n_d;
    logic          tx_en_q, tx_en_d;
    logic          busy_q, busy_d;
    logic          accept, load, hb_end;

`ifdef MIL_TX_PARITY_INJECT_EN
    logic hold_inj_d;
`else
    assign hold_inj_q = 1'b0;
`endif

    // The whole frame is expanded into half-bit levels when it is loaded.
    // After that, sending is just a shift register.
    function automatic logic [39:0] build_frame(input logic [15:0] d,
                                                input logic t,
                                                input logic inj);
        logic [39:0] f;
        logic        p;
        f[39:34] = t ? 6'b111000 : 6'b000111;
        for (int i = 0; i < 16; i++)
            f[33-2*i -: 2] = d[15-i] ? 2'b10 : 2'b01;
        p = (~^d) ^ inj;
        f[1:0] = p ? 2'b10 : 2'b01;
        return f;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        load    = 1'b0;
        accept  = in_request & ~hold_full_q;
        hb_end  = (cnt_q == CNT_LAST);

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                cnt_d = hb_end ? '0 : cnt_q + 1'b1;
                if (hb_end) begin
                    if (idx_q == FRAME_LAST) begin
                        idx_d = '0;
                        // A waiting word starts its sync on the very next cycle.
                        if (hold_full_q) load = 1'b1;
                        else             state_d = GAP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        frame_d = {frame_q[38:0], 1'b0};
                    end
                end
            end
            GAP: begin
                cnt_d = hb_end ? '0 : cnt_q + 1'b1;
                if (hb_end) begin
                    if (idx_q == GAP_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            frame_d = build_frame(hold_data_q, hold_type_q, hold_inj_q);
            cnt_d   = '0;
            idx_d   = '0;
        end

        // Acceptance only fills an empty register. A load only empties a
        // full one, so the two never happen on the same edge.
        hold_full_d = accept ? 1'b1 : (load ? 1'b0 : hold_full_q);
        hold_data_d = accept ? in_data : hold_data_q;
        hold_type_d = accept ? in_type : hold_type_q;
`ifdef MIL_TX_PARITY_INJECT_EN
        hold_inj_d  = accept ? parity_inject : hold_inj_q;
`endif
        in_done_d   = accept;

        // Line outputs are registered and run one cycle behind the state.
        tx_en_d  = (state_q == SEND);
        line_p_d = tx_en_d &  frame_q[39];
        line_n_d = tx_en_d & ~frame_q[39];
        // tx_busy rises on the acceptance edge. It falls on the same cycle
        // the line's idle gap ends, so it lines up with the delayed outputs.
        busy_d   = (state_q != IDLE) | hold_full_q | hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            frame_q     <= '0;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_type_q <= 1'b0;
            in_done_q   <= 1'b0;
            line_p_q    <= 1'b0;
            line_n_q    <= 1'b0;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            hold_type_q <= hold_type_d;
            in_done_q   <= in_done_d;
            line_p_q    <= line_p_d;
            line_n_q    <= line_n_d;
            tx_en_q     <= tx_en_d;
            busy_q      <= busy_d;
        end
    end

`ifdef MIL_TX_PARITY_INJECT_EN
    always_ff @(posedge clk) begin
        if (!rst) hold_inj_q <= 1'b0;
        else      hold_inj_q <= hold_inj_d;
    end
`endif

    assign in_done   = in_done_q;
    assign line_p    = line_p_q;
    assign line_n    = line_n_q;
    assign tx_enable = tx_en_q;
    assign tx_busy   = busy_q;

endmodule

// File: tb/tb_mil_manchester_transmitter.sv
// Testbench for mil_manchester_transmitter, built with CLK_PER_HALFBIT=2 and
// GAP_HALFBITS=8. A monitor logs every output on each falling clock edge.
// Each scenario task drives words and then compares the log against frames
// derived directly from the Manchester-II framing rules.
module tb_mil_manchester_transmitter;

    localparam int CPH       = 2;
    localparam int GAPH      = 8;
    localparam int FRAME_CYC = 40 * CPH;
    localparam int GAP_CYC   = GAPH * CPH;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_type;
    logic        in_request;
    logic        in_done, line_p, line_n, tx_enable, tx_busy;
`ifdef MIL_TX_PARITY_INJECT_EN
    logic        parity_inject;
`endif

    int checks   = 0;
    int failures = 0;

    logic lp_log[$], ln_log[$], en_log[$], busy_log[$], done_log[$];

    mil_manchester_transmitter #(.CLK_PER_HALFBIT(CPH), .GAP_HALFBITS(GAPH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_type    (in_type),
        .in_request (in_request),
`ifdef MIL_TX_PARITY_INJECT_EN
        .parity_inject (parity_inject),
`endif
        .in_done    (in_done),
        .line_p     (line_p),
        .line_n     (line_n),
        .tx_enable  (tx_enable),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        lp_log.push_back(line_p);
        ln_log.push_back(line_n);
        en_log.push_back(tx_enable);
        busy_log.push_back(tx_busy);
        done_log.push_back(in_done);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference model: the line level for half-bit h of a word, taken
    // straight from the framing rules.
    function automatic logic exp_level(input logic [15:0] d, input logic t,
                                       input logic inj, input int h);
        int   b;
        logic v, p;
        p = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;  // makes total ones odd
        p = p ^ inj;
        if (h < 3) return t;
        if (h < 6) return ~t;
        if (h < 38) begin
            b = (h - 6) / 2;
            v = d[15-b];
            return ((h % 2) == 0) ? v : ~v;
        end
        return (h == 38) ? p : ~p;
    endfunction

    function automatic logic [FRAME_CYC-1:0] exp_frame(input logic [15:0] d,
                                                       input logic t, input logic inj);
        logic [FRAME_CYC-1:0] v;
        for (int h = 0; h < 40; h++)
            for (int c = 0; c < CPH; c++)
                v[FRAME_CYC-1-(h*CPH+c)] = exp_level(d, t, inj, h);
        return v;
    endfunction

    function automatic logic [FRAME_CYC-1:0] obs_frame(input int s);
        logic [FRAME_CYC-1:0] v;
        for (int i = 0; i < FRAME_CYC; i++)
            v[FRAME_CYC-1-i] = (s >= 0 && s + i < lp_log.size()) ? lp_log[s+i] : 1'bx;
        return v;
    endfunction

    function automatic int find_rise(input int from);
        for (int i = from; i < en_log.size(); i++)
            if (en_log[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int find_done(input int from, input int nth);
        int n = 0;
        for (int i = from; i < done_log.size(); i++)
            if (done_log[i] === 1'b1) begin
                if (n == nth) return i;
                n++;
            end
        return -1;
    endfunction

    function automatic int run_len(input int from, input logic val);
        int n = 0;
        if (from < 0) return 0;
        while (from + n < en_log.size() && en_log[from+n] === val) n++;
        return n;
    endfunction

    // Driver: present a word and hold the request until in_done is seen.
    // lat is the number of cycles to in_done, or -1 on timeout.
    task automatic push(input logic [15:0] d, input logic t, input logic inj, output int lat);
        in_data    = d;
        in_type    = t;
        in_request = 1'b1;
`ifdef MIL_TX_PARITY_INJECT_EN
        parity_inject = inj;
`endif
        lat = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (in_done === 1'b1) begin
                lat = k;
                break;
            end
        end
        in_request = 1'b0;
`ifdef MIL_TX_PARITY_INJECT_EN
        parity_inject = 1'b0;
`endif
    endtask

    // Wait until the transmitter is fully idle. ok=0 if the bound expires.
    task automatic settle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (tx_busy === 1'b0 && tx_enable === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; in_request = 1'b0; in_data = '0; in_type = 1'b0;
`ifdef MIL_TX_PARITY_INJECT_EN
        parity_inject = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({line_p, line_n, tx_enable, tx_busy, in_done} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {line_p, line_n, tx_enable, tx_busy, in_done});
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({line_p, line_n, tx_enable, tx_busy, in_done} !== 5'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got %b want 00000",
                     {line_p, line_n, tx_enable, tx_busy, in_done});
        end
    endtask

    task automatic test_single_cmd;
        int st, lat, di, f, n_gap;
        bit ok, gap_line_ok;
        st = lp_log.size();
        @(posedge clk); #1;
        push(16'hAB00, 1'b1, 1'b0, lat);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL done_latency: got %0d want 1", lat); end
        settle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL settle_single: got busy want idle"); end
        di = find_done(st, 0);
        f  = find_rise(st);
        checks++;
        if (di < 0 || f - di !== 2) begin
            failures++; $display("FAIL sync_latency: got %0d want 2", f - di);
        end
        checks++;
        if (obs_frame(f) !== exp_frame(16'hAB00, 1'b1, 1'b0)) begin
            failures++; $display("FAIL frame_ab00: got %h want %h",
                                 obs_frame(f), exp_frame(16'hAB00, 1'b1, 1'b0));
        end
        checks++;
        if (run_len(f, 1'b1) !== FRAME_CYC) begin
            failures++; $display("FAIL frame_len: got %0d want %0d", run_len(f, 1'b1), FRAME_CYC);
        end
        n_gap = 0;
        gap_line_ok = 1'b1;
        while (f + FRAME_CYC + n_gap < en_log.size() && en_log[f+FRAME_CYC+n_gap] === 1'b0
               && busy_log[f+FRAME_CYC+n_gap] === 1'b1) begin
            if (lp_log[f+FRAME_CYC+n_gap] !== 1'b0 || ln_log[f+FRAME_CYC+n_gap] !== 1'b0)
                gap_line_ok = 1'b0;
            n_gap++;
        end
        checks++;
        if (n_gap !== GAP_CYC) begin
            failures++; $display("FAIL gap_len: got %0d want %0d", n_gap, GAP_CYC);
        end
        checks++;
        if (gap_line_ok !== 1'b1) begin
            failures++; $display("FAIL gap_line_idle: got active want 0/0");
        end
    endtask

    task automatic test_data_zero;
        int st, lat, f;
        bit ok;
        st = lp_log.size();
        push(16'h0000, 1'b0, 1'b0, lat);
        settle(ok);
        checks++;
        if (lat < 0 || !ok) begin failures++; $display("FAIL zero_handshake: got lat=%0d ok=%0d want done+idle", lat, ok); end
        f = find_rise(st);
        checks++;
        if (obs_frame(f) !== exp_frame(16'h0000, 1'b0, 1'b0)) begin
            failures++; $display("FAIL frame_0000: got %h want %h",
                                 obs_frame(f), exp_frame(16'h0000, 1'b0, 1'b0));
        end
        checks++;
        if (f < 0 || lp_log[f+76] !== 1'b1) begin
            failures++; $display("FAIL parity_0000: got %b want 1", (f < 0) ? 1'bx : lp_log[f+76]);
        end
    endtask

    task automatic test_back_to_back;
        int st, l1, l2, f, d2;
        bit ok;
        st = lp_log.size();
        push(16'h02A2, 1'b1, 1'b0, l1);
        push(16'hEFAB, 1'b0, 1'b0, l2);
        settle(ok);
        checks++;
        if (l1 < 0 || l2 < 0 || !ok) begin
            failures++; $display("FAIL b2b_handshake: got l1=%0d l2=%0d ok=%0d want done+idle", l1, l2, ok);
        end
        f  = find_rise(st);
        d2 = find_done(st, 1);
        checks++;
        if (d2 < 0 || d2 >= f + FRAME_CYC) begin
            failures++; $display("FAIL second_done_early: got %0d want < %0d", d2, f + FRAME_CYC);
        end
        checks++;
        if (run_len(f, 1'b1) !== 2 * FRAME_CYC) begin
            failures++; $display("FAIL contig_len: got %0d want %0d", run_len(f, 1'b1), 2 * FRAME_CYC);
        end
        checks++;
        if (obs_frame(f) !== exp_frame(16'h02A2, 1'b1, 1'b0)) begin
            failures++; $display("FAIL frame_02a2: got %h want %h",
                                 obs_frame(f), exp_frame(16'h02A2, 1'b1, 1'b0));
        end
        checks++;
        if (obs_frame(f + FRAME_CYC) !== exp_frame(16'hEFAB, 1'b0, 1'b0)) begin
            failures++; $display("FAIL frame_efab: got %h want %h",
                                 obs_frame(f + FRAME_CYC), exp_frame(16'hEFAB, 1'b0, 1'b0));
        end
        checks++;
        if (f < 0 || lp_log[f+76] !== 1'b1) begin
            failures++; $display("FAIL parity_02a2: got %b want 1", (f < 0) ? 1'bx : lp_log[f+76]);
        end
    endtask

    task automatic test_held_three;
        int st, lat, f, d3;
        logic [15:0] w[3];
        logic        t[3];
        bit ok;
        st = lp_log.size();
        for (int i = 0; i < 3; i++) begin
            w[i] = 16'($urandom);
            t[i] = 1'($urandom);
        end
        for (int i = 0; i < 3; i++) begin
            push(w[i], t[i], 1'b0, lat);
            checks++;
            if (lat < 0) begin failures++; $display("FAIL held_done_%0d: got timeout want pulse", i); end
        end
        settle(ok);
        f  = find_rise(st);
        d3 = find_done(st, 2);
        checks++;
        if (d3 < f + FRAME_CYC || d3 > f + FRAME_CYC + 2) begin
            failures++; $display("FAIL third_withheld: got %0d want %0d..%0d",
                                 d3, f + FRAME_CYC, f + FRAME_CYC + 2);
        end
        checks++;
        if (run_len(f, 1'b1) !== 3 * FRAME_CYC) begin
            failures++; $display("FAIL held_contig: got %0d want %0d", run_len(f, 1'b1), 3 * FRAME_CYC);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_frame(f + i * FRAME_CYC) !== exp_frame(w[i], t[i], 1'b0)) begin
                failures++; $display("FAIL held_frame_%0d: got %h want %h", i,
                                     obs_frame(f + i * FRAME_CYC), exp_frame(w[i], t[i], 1'b0));
            end
        end
    endtask

    task automatic test_reset_midframe;
        int st, lat, f;
        logic [15:0] w;
        logic        t;
        bit seen, ok;
        push(16'($urandom), 1'($urandom), 1'b0, lat);
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_enable === 1'b1) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL midframe_start: got no frame want tx_enable"); end
        repeat (40) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({line_p, line_n, tx_enable, tx_busy} !== 4'b0) begin
            failures++; $display("FAIL reset_midframe: got %b want 0000",
                                 {line_p, line_n, tx_enable, tx_busy});
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (tx_busy !== 1'b0 || tx_enable !== 1'b0) begin
            failures++; $display("FAIL partial_discarded: got busy=%b en=%b want 0 0", tx_busy, tx_enable);
        end
        st = lp_log.size();
        w = 16'($urandom);
        t = 1'($urandom);
        push(w, t, 1'b0, lat);
        settle(ok);
        f = find_rise(st);
        checks++;
        if (obs_frame(f) !== exp_frame(w, t, 1'b0)) begin
            failures++; $display("FAIL post_reset_frame: got %h want %h", obs_frame(f), exp_frame(w, t, 1'b0));
        end
    endtask

    task automatic test_random;
        localparam int N = 8;
        logic [15:0] wq[$];
        logic        tq[$];
        logic [15:0] w;
        logic        t;
        int st, lat, i, run, frames, done_cnt, bad_pol, bad_frames, short_gaps;
        bit ok;
        st = lp_log.size();
        for (int k = 0; k < N; k++) begin
            w = 16'($urandom);
            t = 1'($urandom);
            wq.push_back(w);
            tq.push_back(t);
            push(w, t, 1'b0, lat);
            checks++;
            if (lat < 0) begin failures++; $display("FAIL rand_done_%0d: got timeout want pulse", k); end
            repeat ($urandom_range(0, 120)) @(posedge clk);
            #1;
        end
        settle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rand_settle: got busy want idle"); end
        i = st; frames = 0; bad_frames = 0; short_gaps = 0;
        while (i < en_log.size()) begin
            if (en_log[i] === 1'b1) begin
                run = run_len(i, 1'b1);
                checks++;
                if (run % FRAME_CYC != 0) begin
                    failures++; $display("FAIL rand_run_len: got %0d want multiple of %0d", run, FRAME_CYC);
                end
                for (int k = 0; k < run / FRAME_CYC; k++) begin
                    if (wq.size() > 0) begin
                        w = wq.pop_front();
                        t = tq.pop_front();
                        if (obs_frame(i + k * FRAME_CYC) !== exp_frame(w, t, 1'b0)) bad_frames++;
                    end
                end
                frames += run / FRAME_CYC;
                i += run;
            end else begin
                run = run_len(i, 1'b0);
                if (frames > 0 && i + run < en_log.size() && run < GAP_CYC) short_gaps++;
                i += (run > 0) ? run : 1;
            end
        end
        checks++;
        if (bad_frames !== 0) begin failures++; $display("FAIL rand_frames: got %0d bad want 0", bad_frames); end
        checks++;
        if (frames !== N) begin failures++; $display("FAIL rand_frame_count: got %0d want %0d", frames, N); end
        checks++;
        if (short_gaps !== 0) begin failures++; $display("FAIL rand_gap_min: got %0d short want 0", short_gaps); end
        done_cnt = 0; bad_pol = 0;
        for (int k = st; k < lp_log.size(); k++) begin
            if (done_log[k] === 1'b1) done_cnt++;
            if (en_log[k] === 1'b1 ? (ln_log[k] !== ~lp_log[k])
                                   : (lp_log[k] !== 1'b0 || ln_log[k] !== 1'b0)) bad_pol++;
        end
        checks++;
        if (done_cnt !== N) begin failures++; $display("FAIL rand_done_count: got %0d want %0d", done_cnt, N); end
        checks++;
        if (bad_pol !== 0) begin failures++; $display("FAIL line_polarity: got %0d bad cycles want 0", bad_pol); end
    endtask

`ifdef MIL_TX_PARITY_INJECT_EN
    task automatic test_parity_inject;
        int st, lat, f;
        logic [15:0] w;
        logic        t;
        bit ok;
        st = lp_log.size();
        w = 16'($urandom);
        t = 1'($urandom);
        push(16'h9D4E, 1'b1, 1'b1, lat);
        push(w, t, 1'b0, lat);
        settle(ok);
        f = find_rise(st);
        checks++;
        if (f < 0 || lp_log[f+76] !== 1'b1) begin
            failures++; $display("FAIL inject_parity: got %b want 1", (f < 0) ? 1'bx : lp_log[f+76]);
        end
        checks++;
        if (obs_frame(f) !== exp_frame(16'h9D4E, 1'b1, 1'b1)) begin
            failures++; $display("FAIL inject_frame: got %h want %h", obs_frame(f), exp_frame(16'h9D4E, 1'b1, 1'b1));
        end
        checks++;
        if (obs_frame(f + FRAME_CYC) !== exp_frame(w, t, 1'b0)) begin
            failures++; $display("FAIL after_inject_frame: got %h want %h",
                                 obs_frame(f + FRAME_CYC), exp_frame(w, t, 1'b0));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_cmd();
        test_data_zero();
        test_back_to_back();
        test_held_three();
        test_reset_midframe();
        test_random();
`ifdef MIL_TX_PARITY_INJECT_EN
        test_parity_inject();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mil_manchester_transmitter.md
Name: mil_manchester_transmitter

Overview:
- Final stage of the SPI-to-MIL path. Sits directly downstream of the service-protocol encoder and consumes its MIL push bus: 16-bit word plus word type.
- Serialises each word into a MIL-STD-1553 Manchester-II frame: 3-bit sync, 16 data bits MSB first, odd parity.
- Drives the differential line pair and the transceiver enable.
- Has a one-word holding register, so back-to-back words leave with no gap.

Parameters:
CLK_PER_HALFBIT, 25, clk cycles per half bit time (50 MHz clk, 1 Mbit/s line)
GAP_HALFBITS, 8, idle half-bits forced after the last word of a burst (4 us at default)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
in_data  input  16  word from the encoder
in_type  input  1  1 = command/status sync, 0 = data sync
in_request  input  1  encoder has a word pending; held until in_done
in_done  output  1  one-cycle pulse, word latched into holding register
line_p  output  1  positive line phase
line_n  output  1  negative line phase
tx_enable  output  1  transceiver drive enable (inhibit when 0)
tx_busy  output  1  high from word acceptance until gap end

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs are 0; holding register is empty; state = IDLE.
  - Applies mid-frame: line drops to 0/0 on the next cycle; the partial word is discarded.
- Handshake:
  - in_done pulses for 1 cycle on the edge where in_request=1 and the holding register is empty; the word and type are captured on that edge.
  - The encoder must drop in_request or present the next word in the cycle after in_done.
  - No acceptance while the holding register is full.
- Line coding:
  - line_n = ~line_p whenever tx_enable=1; line_p = line_n = 0 when tx_enable=0.
  - Data bit 1 = high half then low half; bit 0 = low half then high half.
  - Command sync = 3 half-bits high, then 3 low. Data sync = 3 low, then 3 high.
  - Parity bit = ~^data (odd parity over 16 data bits plus parity).
  - Frame = 40 half-bits = 40*CLK_PER_HALFBIT cycles.
- Timing:
  - Half-bit counter counts 0..CLK_PER_HALFBIT-1 and wraps.
  - Bit index counts 0..39; 0-5 are sync, 6-37 are data, 38-39 are parity.
- States:
  - IDLE: if the holding register is full, on the next cycle load it into the shift register, clear the holding register, set tx_enable=1, go to SEND.
  - SEND: at the end of half-bit 39:
    - holding register full: reload and stay in SEND; next sync starts on the very next cycle (contiguous words).
    - otherwise: go to GAP with tx_enable=0.
  - GAP: hold line 0/0 for GAP_HALFBITS*CLK_PER_HALFBIT cycles, then go to IDLE and drop tx_busy.
  - A word accepted during GAP waits for GAP to finish.
- Latency: in_done to first sync half-bit on line is 2 cycles from IDLE.
- A new word is accepted while SEND is in progress, once the holding register has emptied. Simultaneous acceptance and end-of-frame reload do not occur: reload uses the register contents present before the edge, and acceptance only fills an empty register.
- tx_busy = 1 in SEND, in GAP, or whenever the holding register is full.

Optional Feature:
- Macro MIL_TX_PARITY_INJECT_EN adds input port parity_inject (1 bit), sampled together with in_request at acceptance.
- With the macro, a word captured with parity_inject=1 transmits an inverted parity bit; used for remote-terminal error testing.
- Without the macro, the port does not exist and parity is always correct.

Test Plan:
- CLK_PER_HALFBIT=2, GAP_HALFBITS=8. Push 16'hAB00, type 1 ->
  - in_done 1 cycle after request.
  - line_p by half-bit: 111000 sync, then bits 1010101100000000, then parity 0.
  - Frame is 80 cycles; tx_enable then drops for 16 cycles.
- Push 16'h0000, type 0 -> data sync 000111, 16 zero bits each low/high, parity bit 1.
- Back-to-back 16'h02A2 (cmd) then 16'hEFAB (data), second request raised during the first frame ->
  - second in_done arrives before frame 1 ends.
  - no idle cycle between the two frames; 16'h02A2 parity = 1; 160 contiguous cycles of tx_enable=1.
- Hold in_request for 3 words while a frame is in flight -> third in_done is withheld until the first reload empties the holding register.
- Assert rst=0 at half-bit 20 of a frame -> next cycle line_p=line_n=0, tx_enable=0, tx_busy=0; after release, a new word transmits correctly.
- With MIL_TX_PARITY_INJECT_EN, push 16'h9D4E with parity_inject=1 -> parity bit 1 (correct value is 0); the following word without inject has correct parity.
